// File: rtl/hwag_pkg.sv
// Shared constants for the angle-generator blocks: default datapath width and
// the period divider controller state encoding.
package hwag_pkg;

  localparam int unsigned DefWidth = 24;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StLoad = 2'd1;
  localparam state_t StRun  = 2'd2;
  localparam state_t StDone = 2'd3;

endpackage

// File: rtl/integer_div.sv
// Restoring unsigned divider, one quotient bit per clock. A low start reloads the
// operands; a high start iterates until rdy and then holds the result.
module integer_div #(
  parameter int unsigned WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divider,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             rdy
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;
  logic             fits;

  // Partial remainder is always below divider, so the subtraction fits in WIDTH bits.
  always_comb begin
    trial = {rem_q, quo_q[WIDTH-1]};
    fits  = (trial >= {1'b0, divider});
    diff  = trial[WIDTH-1:0] - divider;
    rdy   = (cnt_q == CntW'(WIDTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
    end else if (!start) begin
      quo_q <= dividend;
      rem_q <= '0;
      cnt_q <= '0;
    end else if (!rdy) begin
      rem_q <= fits ? diff : trial[WIDTH-1:0];
      quo_q <= {quo_q[WIDTH-2:0], fits};
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/period_div_ctrl.sv
// Converts a captured tooth period into a per-step period by dividing by the
// step count, with a one-deep pending sample buffer and a sticky overrun flag.
module period_div_ctrl
  import hwag_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cap,
  input  logic [WIDTH-1:0] period,
  input  logic [WIDTH-1:0] steps,
  input  logic             ovf_clr,
  output logic             busy,
  output logic [WIDTH-1:0] step_period,
  output logic [WIDTH-1:0] step_rem,
  output logic             valid,
  output logic             div0,
  output logic             ovf
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_period_q, op_period_d, op_steps_q, op_steps_d;
  logic [WIDTH-1:0] pend_period_q, pend_period_d, pend_steps_q, pend_steps_d;
  logic             pend_valid_q, pend_valid_d;
  logic [WIDTH-1:0] step_period_q, step_period_d, step_rem_q, step_rem_d;
  logic             valid_q, valid_d, div0_q, div0_d, ovf_q, ovf_d;
  logic             overrun, have, start, rdy;
  logic [WIDTH-1:0] cand_period, cand_steps, quotient, remainder;

  assign start = (state_q == StRun);

  always_comb begin
    state_d       = state_q;
    op_period_d   = op_period_q;
    op_steps_d    = op_steps_q;
    pend_period_d = pend_period_q;
    pend_steps_d  = pend_steps_q;
    pend_valid_d  = pend_valid_q;
    step_period_d = step_period_q;
    step_rem_d    = step_rem_q;
    valid_d       = 1'b0;
    div0_d        = 1'b0;
    overrun       = 1'b0;
    have          = 1'b0;
    cand_period   = period;
    cand_steps    = steps;

    unique case (state_q)
      StIdle: begin
        if (pend_valid_q) begin
          have         = 1'b1;
          cand_period  = pend_period_q;
          cand_steps   = pend_steps_q;
          pend_valid_d = cap;
          if (cap) begin
            pend_period_d = period;
            pend_steps_d  = steps;
          end
        end else begin
          have = cap;
        end
        if (have) begin
          if (cand_steps != '0) begin
            op_period_d = cand_period;
            op_steps_d  = cand_steps;
            state_d     = StLoad;
          end else begin
            div0_d = 1'b1;
          end
        end
      end
      StLoad, StRun: begin
        if (state_q == StLoad) begin
          state_d = StRun;
        end else if (rdy) begin
          state_d       = StDone;
          step_period_d = quotient;
          step_rem_d    = remainder;
          valid_d       = 1'b1;
        end
        if (cap) begin
          overrun       = pend_valid_q;
          pend_period_d = period;
          pend_steps_d  = steps;
          pend_valid_d  = 1'b1;
        end
      end
      StDone: begin
        // A cap landing here counts as pending; it only overruns a full buffer.
        have    = cap | pend_valid_q;
        overrun = cap & pend_valid_q;
        if (!cap) begin
          cand_period = pend_period_q;
          cand_steps  = pend_steps_q;
        end
        state_d = StIdle;
        if (have && cand_steps != '0) begin
          op_period_d  = cand_period;
          op_steps_d   = cand_steps;
          pend_valid_d = 1'b0;
          state_d      = StLoad;
        end else if (have) begin
          pend_period_d = cand_period;
          pend_steps_d  = cand_steps;
          pend_valid_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    ovf_d = ovf_q;
    if (overrun) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      op_period_q   <= '0;
      op_steps_q    <= '0;
      pend_period_q <= '0;
      pend_steps_q  <= '0;
      pend_valid_q  <= 1'b0;
      step_period_q <= '0;
      step_rem_q    <= '0;
      valid_q       <= 1'b0;
      div0_q        <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_period_q   <= op_period_d;
      op_steps_q    <= op_steps_d;
      pend_period_q <= pend_period_d;
      pend_steps_q  <= pend_steps_d;
      pend_valid_q  <= pend_valid_d;
      step_period_q <= step_period_d;
      step_rem_q    <= step_rem_d;
      valid_q       <= valid_d;
      div0_q        <= div0_d;
      ovf_q         <= ovf_d;
    end
  end

  integer_div #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dividend (op_period_q),
    .divider  (op_steps_q),
    .quotient (quotient),
    .remainder(remainder),
    .rdy      (rdy)
  );

  assign busy        = (state_q != StIdle);
  assign step_period = step_period_q;
  assign step_rem    = step_rem_q;
  assign valid       = valid_q;
  assign div0        = div0_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_period_div_ctrl.sv
// Directed bench for period_div_ctrl: expected results are queued at capture time
// and compared when valid/div0 appears.
module tb_period_div_ctrl;

  localparam int unsigned W = 24;

  typedef struct packed {
    logic         d0;
    logic [W-1:0] q;
    logic [W-1:0] r;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cap = 1'b0;
  logic [W-1:0] period = '0;
  logic [W-1:0] steps = '0;
  logic         ovf_clr = 1'b0;
  logic         busy, valid, div0, ovf;
  logic [W-1:0] step_period, step_rem;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int cap_cyc = 0;
  int last_valid_cyc = 0;
  int n_valid = 0;
  int snap;
  exp_t sb[$];

  period_div_ctrl #(
    .WIDTH(W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cap        (cap),
    .period     (period),
    .steps      (steps),
    .ovf_clr    (ovf_clr),
    .busy       (busy),
    .step_period(step_period),
    .step_rem   (step_rem),
    .valid      (valid),
    .div0       (div0),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Scoreboard side: pop one expectation per output strobe.
  always @(negedge clk) begin
    if (!rst && (valid || div0)) begin
      exp_t e;
      if (valid) begin
        n_valid++;
        last_valid_cyc = cyc;
      end
      if (sb.size() == 0) begin
        check("unexpected_strobe", {30'd0, valid, div0}, 32'd0);
      end else begin
        e = sb.pop_front();
        if (e.d0) begin
          check("div0_kind", {30'd0, valid, div0}, 32'd1);
        end else begin
          check("valid_kind", {30'd0, valid, div0}, 32'd2);
          check("step_period", 32'(step_period), 32'(e.q));
          check("step_rem", 32'(step_rem), 32'(e.r));
        end
      end
    end
  end

  task automatic do_cap(input logic [W-1:0] p, input logic [W-1:0] s, input bit push);
    exp_t e;
    @(negedge clk);
    cap = 1'b1;
    period = p;
    steps = s;
    cap_cyc = cyc;
    if (push) begin
      e.d0 = (s == '0);
      e.q  = (s == '0) ? '0 : p / s;
      e.r  = (s == '0) ? '0 : p % s;
      sb.push_back(e);
    end
    @(negedge clk);
    cap = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || sb.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle_timeout", 32'(n >= 300), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_div0", 32'(div0), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_step_period", 32'(step_period), 32'd0);
    check("rst_step_rem", 32'(step_rem), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1000/32 with latency: LOAD + WIDTH iterations + rdy cycle + DONE.
    do_cap(24'd1000, 24'd32, 1'b1);
    wait_idle();
    check("latency", 32'(last_valid_cyc - cap_cyc), 32'(W + 3));
    check("busy_after", 32'(busy), 32'd0);
    check("hold_period", 32'(step_period), 32'd31);

    do_cap(24'hFFFFFF, 24'd1, 1'b1);
    wait_idle();

    // Divide by zero: div0 only, result registers untouched.
    snap = n_valid;
    do_cap(24'd500, 24'd0, 1'b1);
    wait_idle();
    repeat (2) @(negedge clk);
    check("div0_hold_period", 32'(step_period), 32'hFFFFFF);
    check("div0_hold_rem", 32'(step_rem), 32'd0);
    check("div0_no_valid", 32'(n_valid - snap), 32'd0);

    // Overrun: 900/7 is overwritten by 700/7.
    do_cap(24'd600, 24'd7, 1'b1);
    repeat (5) @(negedge clk);
    do_cap(24'd900, 24'd7, 1'b0);
    do_cap(24'd700, 24'd7, 1'b1);
    wait_idle();
    check("ovf_set", 32'(ovf), 32'd1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("ovf_cleared", 32'(ovf), 32'd0);

    // Reset mid-RUN, then a fresh operation with a single valid.
    do_cap(24'd1000, 24'd32, 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_step_period", 32'(step_period), 32'd0);
    check("mid_rst_step_rem", 32'(step_rem), 32'd0);
    check("mid_rst_flags", {29'd0, valid, div0, ovf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    snap = n_valid;
    repeat (2) @(negedge clk);
    check("post_rst_no_valid", 32'(n_valid - snap), 32'd0);
    do_cap(24'd64, 24'd8, 1'b1);
    wait_idle();
    repeat (3) @(negedge clk);
    check("post_rst_single_valid", 32'(n_valid - snap), 32'd1);

    // Cap coincident with DONE goes to pending without overrun.
    do_cap(24'd120, 24'd10, 1'b1);
    begin
      int n = 0;
      while (!valid && n < 300) begin
        @(negedge clk);
        n++;
      end
      check("done_wait_timeout", 32'(n >= 300), 32'd0);
    end
    begin
      exp_t e;
      cap = 1'b1;
      period = 24'd50;
      steps = 24'd5;
      e.d0 = 1'b0;
      e.q = 24'd10;
      e.r = 24'd0;
      sb.push_back(e);
      @(negedge clk);
      cap = 1'b0;
    end
    wait_idle();
    check("done_cap_ovf", 32'(ovf), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
